// File: rtl/sprite_anim_ctrl.sv
// Sprite ROM address pipeline and idle-animation frame sequencer.
// Two-stage scan-to-address path plus a frame/hold counter FSM in the vga_clk domain.
module sprite_anim_ctrl #(
   parameter int SPR_W      = 64,
   parameter int SPR_H      = 96,
   parameter int NUM_FRAMES = 5,
   parameter int HOLD_TICKS = 6
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        anim_en,
   input  logic        freeze,
   input  logic        restart,
   input  logic        flip,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   output logic [14:0] rom_address,
   output logic        sprite_hit,
   output logic [2:0]  frame_idx
);

   localparam int AW = 15;
   localparam int XW = $clog2(SPR_W);
   localparam int YW = AW - XW;
   localparam int HW = $clog2(HOLD_TICKS);

   localparam logic [10:0]   W11       = 11'(SPR_W);
   localparam logic [10:0]   H11       = 11'(SPR_H);
   localparam logic [AW-1:0] FRAME_SZ  = AW'(SPR_W * SPR_H);
   localparam logic [2:0]    FRAME_MAX = 3'(NUM_FRAMES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      FROZEN = 2'd2
   } state_t;

   state_t          state_q, state_n;
   logic [2:0]      frame_n;
   logic [HW-1:0]   hold_cnt, hold_n;
   logic [AW-1:0]   frame_base, base_n;

   logic [10:0]     dx_n, dy_n;
   logic            hit_n;
   logic [XW-1:0]   dx_r;
   logic [YW-1:0]   dy_r;
   logic            hit_r;
   logic [XW-1:0]   col;
   logic [AW-1:0]   row_off;
   logic [AW-1:0]   addr_n;

   // MSB of the 11-bit difference is the borrow: scan left of / above the sprite.
   always_comb begin
      dx_n  = {1'b0, draw_x} - {1'b0, pos_x};
      dy_n  = {1'b0, draw_y} - {1'b0, pos_y};
      hit_n = ~dx_n[10] & ~dy_n[10] & (dx_n < W11) & (dy_n < H11);
   end

   // SPR_W is a power of two, so SPR_W-1-dx is just the bitwise complement.
   always_comb begin
      col     = flip ? ~dx_r : dx_r;
      row_off = {dy_r, {XW{1'b0}}};
      addr_n  = frame_base + row_off + AW'(col);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         dx_r        <= '0;
         dy_r        <= '0;
         hit_r       <= 1'b0;
         rom_address <= '0;
         sprite_hit  <= 1'b0;
      end else begin
         dx_r        <= dx_n[XW-1:0];
         dy_r        <= dy_n[YW-1:0];
         hit_r       <= hit_n;
         rom_address <= hit_r ? addr_n : '0;
         sprite_hit  <= hit_r;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_q    <= IDLE;
         frame_idx  <= '0;
         hold_cnt   <= '0;
         frame_base <= '0;
      end else begin
         state_q    <= state_n;
         frame_idx  <= frame_n;
         hold_cnt   <= hold_n;
         frame_base <= base_n;
      end
   end

   always_comb begin
      state_n = state_q;
      frame_n = frame_idx;
      hold_n  = hold_cnt;
      base_n  = frame_base;
      if (!anim_en) begin
         state_n = IDLE;
         frame_n = '0;
         hold_n  = '0;
         base_n  = '0;
      end else begin
         unique case (state_q)
            IDLE: state_n = PLAY;
            PLAY: begin
               if (restart) begin
                  frame_n = '0;
                  hold_n  = '0;
                  base_n  = '0;
               end else if (freeze) begin
                  state_n = FROZEN;
               end else if (frame_tick) begin
                  if (hold_cnt == HOLD_MAX) begin
                     hold_n = '0;
                     if (frame_idx == FRAME_MAX) begin
                        frame_n = '0;
                        base_n  = '0;
                     end else begin
                        frame_n = frame_idx + 3'd1;
                        base_n  = frame_base + FRAME_SZ;
                     end
                  end else begin
                     hold_n = hold_cnt + 1'b1;
                  end
               end
            end
            FROZEN: begin
               if (restart) begin
                  frame_n = '0;
                  hold_n  = '0;
                  base_n  = '0;
               end else if (!freeze) begin
                  state_n = PLAY;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl: directed scenarios plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_sprite_anim_ctrl;

   localparam int SPR_W      = 64;
   localparam int SPR_H      = 96;
   localparam int NUM_FRAMES = 5;
   localparam int HOLD_TICKS = 6;

   logic        vga_clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic        anim_en = 1'b0;
   logic        freeze = 1'b0;
   logic        restart = 1'b0;
   logic        flip = 1'b0;
   logic [9:0]  draw_x = '0;
   logic [9:0]  draw_y = '0;
   logic [9:0]  pos_x = '0;
   logic [9:0]  pos_y = '0;
   logic [14:0] rom_address;
   logic        sprite_hit;
   logic [2:0]  frame_idx;

   sprite_anim_ctrl #(
      .SPR_W(SPR_W), .SPR_H(SPR_H),
      .NUM_FRAMES(NUM_FRAMES), .HOLD_TICKS(HOLD_TICKS)
   ) dut (
      .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick),
      .anim_en(anim_en), .freeze(freeze), .restart(restart),
      .flip(flip), .draw_x(draw_x), .draw_y(draw_y),
      .pos_x(pos_x), .pos_y(pos_y), .rom_address(rom_address),
      .sprite_hit(sprite_hit), .frame_idx(frame_idx)
   );

   always #5 vga_clk = ~vga_clk;

   int n_chk = 0;
   int n_pass = 0;
   bit check_en = 0;

   // reference model state
   int m_frame = 0, m_ticks = 0;
   bit m_active = 0, m_paused = 0;
   int p_dx = 0, p_dy = 0;
   bit p_hit = 0;
   int e_addr = 0;
   bit e_hit = 0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   always @(posedge vga_clk) begin
      if (reset) begin
         m_frame = 0; m_ticks = 0; m_active = 0; m_paused = 0;
         p_dx = 0; p_dy = 0; p_hit = 0; e_addr = 0; e_hit = 0;
      end else begin
         e_hit  = p_hit;
         e_addr = p_hit ? m_frame * SPR_W * SPR_H + p_dy * SPR_W
                  + (flip ? SPR_W - 1 - p_dx : p_dx) : 0;
         p_dx  = int'(draw_x) - int'(pos_x);
         p_dy  = int'(draw_y) - int'(pos_y);
         p_hit = p_dx >= 0 && p_dx < SPR_W && p_dy >= 0 && p_dy < SPR_H;
         if (!anim_en) begin
            m_active = 0; m_paused = 0; m_frame = 0; m_ticks = 0;
         end else if (!m_active) begin
            m_active = 1;
         end else if (restart) begin
            m_frame = 0; m_ticks = 0;
         end else if (m_paused) begin
            if (!freeze) m_paused = 0;
         end else if (freeze) begin
            m_paused = 1;
         end else if (frame_tick) begin
            m_ticks++;
            if (m_ticks == HOLD_TICKS) begin
               m_ticks = 0;
               m_frame = (m_frame + 1) % NUM_FRAMES;
            end
         end
      end
   end

   always @(negedge vga_clk) begin
      if (check_en) begin
         chk("model frame_idx", int'(frame_idx), m_frame);
         chk("model sprite_hit", int'(sprite_hit), int'(e_hit));
         chk("model rom_address", int'(rom_address), e_addr);
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge vga_clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(2);
   endtask

   initial begin
      step(2);
      check_en = 1;
      chk("reset frame_idx", int'(frame_idx), 0);
      chk("reset sprite_hit", int'(sprite_hit), 0);
      chk("reset rom_address", int'(rom_address), 0);
      reset = 1'b0;

      pos_x = 10'd100; pos_y = 10'd200;
      draw_x = 10'd100; draw_y = 10'd200;
      step(2);
      chk("origin hit", int'(sprite_hit), 1);
      chk("origin addr", int'(rom_address), 0);
      draw_x = 10'd163; draw_y = 10'd295;
      step(2);
      chk("corner addr", int'(rom_address), 6143);

      flip = 1'b1;
      draw_x = 10'd100; draw_y = 10'd200;
      step(2);
      chk("flip origin addr", int'(rom_address), 63);
      draw_x = 10'd99;
      step(2);
      chk("borrow hit", int'(sprite_hit), 0);
      chk("borrow addr", int'(rom_address), 0);
      draw_x = 10'd164;
      step(2);
      chk("dx=W hit", int'(sprite_hit), 0);
      draw_x = 10'd163;
      step(2);
      chk("dx=W-1 hit", int'(sprite_hit), 1);

      flip = 1'b0;
      draw_x = 10'd100; draw_y = 10'd200;
      anim_en = 1'b1;
      step(1);
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (n == 5) chk("tick5 frame", int'(frame_idx), 0);
         if (n == 6) begin
            chk("tick6 frame", int'(frame_idx), 1);
            chk("frame1 base", int'(rom_address), 6144);
         end
         if (n == 24) chk("tick24 frame", int'(frame_idx), 4);
         if (n == 30) chk("tick30 wrap", int'(frame_idx), 0);
      end

      repeat (15) tick();
      chk("pre-freeze frame", int'(frame_idx), 2);
      freeze = 1'b1;
      step(1);
      repeat (10) tick();
      chk("frozen frame", int'(frame_idx), 2);
      freeze = 1'b0;
      step(1);
      tick();
      tick();
      chk("resume 2 ticks", int'(frame_idx), 2);
      tick();
      chk("resume 3 ticks", int'(frame_idx), 3);

      tick();
      tick();
      restart = 1'b1;
      frame_tick = 1'b1;
      step(1);
      restart = 1'b0;
      frame_tick = 1'b0;
      chk("restart frame", int'(frame_idx), 0);
      step(2);
      repeat (5) tick();
      chk("restart hold cleared", int'(frame_idx), 0);
      tick();
      chk("restart next advance", int'(frame_idx), 1);

      chk("pre-reset hit", int'(sprite_hit), 1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("mid reset hit", int'(sprite_hit), 0);
      chk("mid reset addr", int'(rom_address), 0);
      chk("mid reset frame", int'(frame_idx), 0);

      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom_range(0, 499) == 0);
         anim_en    = ($urandom_range(0, 299) != 0);
         restart    = ($urandom_range(0, 59) == 0);
         frame_tick = ($urandom_range(0, 2) == 0);
         flip       = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) freeze = ~freeze;
         if ($urandom_range(0, 99) == 0) begin
            pos_x = 10'($urandom_range(0, 660));
            pos_y = 10'($urandom_range(0, 500));
         end
         if ($urandom_range(0, 1) == 1) begin
            draw_x = 10'(int'(pos_x) + int'($urandom_range(0, 70)) - 3);
            draw_y = 10'(int'(pos_y) + int'($urandom_range(0, 102)) - 3);
         end else begin
            draw_x = 10'($urandom_range(0, 639));
            draw_y = 10'($urandom_range(0, 479));
         end
         step(1);
      end

      check_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sprite_anim_ctrl.md
Name: sprite_anim_ctrl

Overview:
Sequences the single-port character sprite ROM / palette path. It converts the VGA scan position and the fighter's screen position into a 15-bit ROM address and a registered in-sprite flag. It steps through a multi-frame idle animation strip stored contiguously in that ROM. It sits between the VGA controller / fighter position logic and the sprite ROM+palette renderer, in the vga_clk domain.

Parameters:
SPR_W, 64, sprite frame width in pixels (power of 2)
SPR_H, 96, sprite frame height in pixels
NUM_FRAMES, 5, frames in the animation strip (NUM_FRAMES*SPR_W*SPR_H <= 32768)
HOLD_TICKS, 6, frame_tick pulses each animation frame is displayed

Ports:
vga_clk  in  1  pixel clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
anim_en  in  1  level; 1 = animate, 0 = hold frame 0
freeze  in  1  level; 1 = pause on current frame (hit-stun)
restart  in  1  one-cycle pulse; return to frame 0
flip  in  1  1 = mirror sprite horizontally (facing left)
draw_x  in  10  current scan column
draw_y  in  10  current scan row
pos_x  in  10  sprite top-left column
pos_y  in  10  sprite top-left row
rom_address  out  15  sprite ROM address
sprite_hit  out  1  scan pixel inside sprite box, aligned with rom_address
frame_idx  out  3  currently displayed animation frame

Behaviour:
- Reset (sync, high): state=IDLE, frame_idx=0, hold_cnt=0, frame_base=0, rom_address=0, sprite_hit=0, all pipeline registers 0. A reset asserted mid-frame takes effect on that edge; the first output is valid 2 cycles after reset deasserts.
- Pipeline, latency 2 cycles from draw_x/draw_y to rom_address/sprite_hit:
  - Stage 1 registers dx = draw_x - pos_x and dy = draw_y - pos_y. Both are 11-bit unsigned differences with the MSB acting as the borrow.
  - Stage 1 also registers hit1 = (no borrow on either) & dx<SPR_W & dy<SPR_H.
  - Stage 2 computes col = flip ? SPR_W-1-dx : dx.
  - Stage 2 sets rom_address = frame_base + dy*SPR_W + col, where dy*SPR_W is a shift, truncated to 15 bits, and sets sprite_hit = hit1.
  - When hit1=0, rom_address=0.
  - flip is sampled in stage 2.
- frame_base = frame_idx*SPR_W*SPR_H. It is maintained by accumulation, with no multiplier, and is updated only on frame_tick cycles, so there is no mid-scan tearing.
- FSM states and transitions:
  - IDLE: entered when anim_en=0. Forces frame_idx=0 and hold_cnt=0. Goes to PLAY when anim_en=1.
  - PLAY: on each frame_tick, hold_cnt increments. When hold_cnt reaches HOLD_TICKS-1, hold_cnt is cleared and frame_idx advances. The frame after NUM_FRAMES-1 wraps to 0, with frame_base returning to 0. freeze=1 goes to FROZEN. anim_en=0 goes to IDLE.
  - FROZEN: frame_idx and hold_cnt are held and frame_tick is ignored. freeze=0 returns to PLAY, resuming the hold count where it stopped. anim_en=0 goes to IDLE.
- Priority on the same cycle: reset > anim_en=0 > restart > freeze > frame_tick.
  - restart clears frame_idx, hold_cnt and frame_base, and keeps the current state; FROZEN stays FROZEN, now on frame 0.
  - restart coincident with frame_tick: restart wins and no advance occurs.
- Edge boundaries:
  - pos_x > draw_x (borrow) gives no hit.
  - A sprite partly past column 639 or row 479 is clipped naturally: no wrap, no hit on the left edge.
  - dx=SPR_W-1 is a hit; dx=SPR_W is not.

Test Plan:
- Reset, then anim_en=0, pos=(100,200), draw=(100,200) → 2 cycles later sprite_hit=1, rom_address=0. With draw=(163,295), rom_address=95*64+63=6143.
- Same setup with flip=1, draw=(100,200) → rom_address=63. With draw=(99,200) → sprite_hit=0, rom_address=0. With draw=(164,200) → sprite_hit=0.
- anim_en=1, issue 30 frame_ticks → frame_idx steps 0→1 after tick 6, …, reaches 4 after tick 24, and wraps to 0 after tick 30. The frame-1 base is checked: draw=pos gives rom_address=6144.
- In frame 2 with hold_cnt=3, assert freeze for 10 frame_ticks, then release → frame_idx stays 2, and the advance to 3 occurs on the 3rd tick after release.
- restart and frame_tick on the same cycle while in frame 3 → frame_idx=0, hold_cnt=0, and no advance.
- Assert reset for 1 cycle mid-scanline while sprite_hit=1 → sprite_hit=0 and rom_address=0 on the next edge, and frame_idx=0.
